atb_sink: RTL and testbench

ATB slave-side trace sink for the 32-bit ATB interface used by the testbench and trace fabric. It accepts beats from an ATB master (atvalid/atready), buffers them in a small FIFO, and presents them on a simple valid/ready drain port. It also drives the slave-owned sideband: the flush request (afvalid/afready) and the periodic synchronisation request (syncreq). It is the receiving end for the trace sources the ATB VIP drives.

---
 rtl/atb_sink.sv | 152 +++++++++++++++
 tb/tb_atb_sink.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atb_sink.sv
// ATB slave-side trace sink: FIFO-buffered beats drained on a valid/ready port,
// plus flush handshake and periodic syncreq (compiled in with ATB_SINK_SYNCREQ_EN).
module atb_sink #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_PERIOD = 256
) (
  input  logic        atclk,
  input  logic        atresetn,
  input  logic        atclken,
  input  logic        atvalid,
  output logic        atready,
  input  logic [31:0] atdata,
  input  logic [2:0]  atbytes,
  input  logic [6:0]  atid,
  output logic        afvalid,
  input  logic        afready,
  output logic        syncreq,
  input  logic        flush_req,
  output logic        flush_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic [6:0]  out_id,
  output logic        proto_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } state_t;

  logic [41:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          atready_q;
  logic          proto_err_q;
  logic          afvalid_q;
  logic          flush_done_q;
  state_t        state_q;

  logic          accept, legal, push, pop;
  logic [41:0]   head;

  always_comb begin
    accept  = atclken & atvalid & atready_q;
    legal   = (atbytes != 3'd0) && (atbytes <= 3'd4);
    push    = accept & legal;
    pop     = (count_q != '0) & out_ready;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge atclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {atdata, atbytes, atid};
    end
  end

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      atready_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      afvalid_q    <= 1'b0;
      flush_done_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      atready_q <= (count_d < FULL);
      if (accept && !legal) proto_err_q <= 1'b1;
      flush_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q   <= FLUSH;
            afvalid_q <= 1'b1;
          end
        end
        FLUSH: begin
          // a beat accepted on this same edge is already in count_d, so it drains as pre-flush
          if (atclken && afready) begin
            state_q   <= DRAIN;
            afvalid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (count_d == '0) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ATB_SINK_SYNCREQ_EN
  localparam int unsigned SW = $clog2(SYNC_PERIOD) + 1;

  logic [SW-1:0] sync_cnt_q, sync_sum;
  logic          syncreq_q;

  assign sync_sum = sync_cnt_q + SW'(atbytes);

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      sync_cnt_q <= '0;
      syncreq_q  <= 1'b0;
    end else if (atclken) begin
      syncreq_q <= 1'b0;
      if (push) begin
        if (sync_sum >= SW'(SYNC_PERIOD)) begin
          sync_cnt_q <= '0;
          syncreq_q  <= 1'b1;
        end else begin
          sync_cnt_q <= sync_sum;
        end
      end
    end
  end

  assign syncreq = syncreq_q;
`else
  // SYNC_PERIOD is never 0, so this is a constant 0 that still references the parameter
  assign syncreq = (SYNC_PERIOD == 0);
`endif

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? head[41:10] : '0;
  assign out_bytes  = out_valid ? head[9:7]   : '0;
  assign out_id     = out_valid ? head[6:0]   : '0;
  assign atready    = atready_q;
  assign afvalid    = afvalid_q;
  assign flush_done = flush_done_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_atb_sink.sv
// Randomised and directed bench for atb_sink against a queue-based reference model.
module tb_atb_sink;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 256;

  logic        atclk, atresetn, atclken, atvalid, atready;
  logic [31:0] atdata;
  logic [2:0]  atbytes;
  logic [6:0]  atid;
  logic        afvalid, afready, syncreq, flush_req, flush_done;
  logic        out_valid, out_ready, proto_err;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic [6:0]  out_id;

  atb_sink #(.DEPTH(DEPTH), .SYNC_PERIOD(SYNC)) dut (
    .atclk(atclk), .atresetn(atresetn), .atclken(atclken),
    .atvalid(atvalid), .atready(atready), .atdata(atdata),
    .atbytes(atbytes), .atid(atid), .afvalid(afvalid), .afready(afready),
    .syncreq(syncreq), .flush_req(flush_req), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_id(out_id), .proto_err(proto_err)
  );

  initial atclk = 1'b0;
  always #5 atclk = ~atclk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
    logic [6:0]  id;
  } beat_t;

  beat_t q[$];
  bit    m_ready, m_perr, m_afv, m_done, m_sync, last_acc;
  int    m_phase;   // 0 idle, 1 waiting for master flush ack, 2 draining
  int    m_sum;
  int    n_vec, n_err;
  int    sync_pulses, done_pulses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ready = 0; m_perr = 0; m_afv = 0; m_done = 0; m_sync = 0;
    m_phase = 0; m_sum = 0; last_acc = 0;
  endtask

  task automatic check_outputs();
    beat_t h;
    h = '{32'h0, 3'h0, 7'h0};
    if (q.size() > 0) h = q[0];
    chk("atready",    32'(atready),    32'(m_ready));
    chk("out_valid",  32'(out_valid),  32'(q.size() > 0));
    chk("out_data",   out_data,        h.d);
    chk("out_bytes",  32'(out_bytes),  32'(h.b));
    chk("out_id",     32'(out_id),     32'(h.id));
    chk("afvalid",    32'(afvalid),    32'(m_afv));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("syncreq",    32'(syncreq),    32'(m_sync));
    chk("proto_err",  32'(proto_err),  32'(m_perr));
  endtask

  // One clock: predict from current inputs, let the edge happen, compare 1ns later.
  task automatic step();
    bit acc, lg, pp;
    acc = atclken && atvalid && m_ready;
    lg  = (atbytes >= 3'd1) && (atbytes <= 3'd4);
    pp  = (q.size() > 0) && out_ready;
    if (pp) void'(q.pop_front());
    if (acc && lg) q.push_back('{atdata, atbytes, atid});
    m_ready = q.size() < DEPTH;
    if (acc && !lg) m_perr = 1;
    m_done = 0;
    if (m_phase == 0 && flush_req) begin
      m_phase = 1; m_afv = 1;
    end else if (m_phase == 1 && atclken && afready) begin
      m_phase = 2; m_afv = 0;
    end else if (m_phase == 2 && q.size() == 0) begin
      m_phase = 0; m_done = 1;
    end
`ifdef ATB_SINK_SYNCREQ_EN
    if (atclken) begin
      m_sync = 0;
      if (acc && lg) begin
        m_sum += int'(atbytes);
        if (m_sum >= SYNC) begin
          m_sum = 0; m_sync = 1;
        end
      end
    end
`endif
    last_acc = acc;
    @(posedge atclk);
    #1;
    check_outputs();
    if (syncreq) sync_pulses++;
    if (flush_done) done_pulses++;
  endtask

  task automatic idle_inputs();
    atclken = 1; atvalid = 0; atdata = '0; atbytes = 3'd4; atid = '0;
    afready = 0; flush_req = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    atresetn = 0;
    #3;
    model_reset();
    check_outputs();
    @(posedge atclk); #1;
    check_outputs();
    atresetn = 1;
  endtask

  int k, bound;

  initial begin
    n_vec = 0; n_err = 0;
    atresetn = 0;
    idle_inputs();
    model_reset();
    @(posedge atclk); #1;
    do_reset();

    // Fill to full with the drain stalled, then let it drain in order.
    atvalid = 1; atbytes = 3'd4; atid = 7'h10; k = 1; atdata = 32'(k);
    repeat (14) begin
      step();
      if (last_acc) begin k++; atdata = 32'(k); end
    end
    chk("fill_count", 32'(k), 32'd9);
    chk("full_ready", 32'(atready), 32'd0);
    out_ready = 1;
    bound = 0;
    while ((atvalid || out_valid) && bound < 40) begin
      step();
      bound++;
      if (last_acc) begin
        if (k == 9) atvalid = 0;
        k++; atdata = 32'(k);
      end
    end
    chk("fill_drain_done", 32'(bound < 40), 32'd1);
    chk("empty_data", out_data, 32'd0);

    // Illegal byte counts are dropped and proto_err sticks.
    atvalid = 1; atbytes = 3'd5; atdata = 32'hDEAD0005; step();
    atbytes = 3'd0; atdata = 32'hDEAD0000; step();
    atbytes = 3'd2; atdata = 32'h0000BEEF;
    repeat (6) step();
    atvalid = 0; repeat (3) step();
    chk("proto_sticky", 32'(proto_err), 32'd1);

    // Flush with 3 beats buffered and the drain running.
    do_reset();
    atvalid = 1; atbytes = 3'd4; atid = 7'h22;
    k = 0; bound = 0;
    while (k < 3 && bound < 20) begin
      atdata = 32'h100 + 32'(k); step(); bound++;
      if (last_acc) k++;
    end
    atvalid = 0; out_ready = 1; flush_req = 1; done_pulses = 0;
    step(); flush_req = 0;
    bound = 0;
    while (!afvalid && bound < 10) begin step(); bound++; end
    chk("afvalid_rise", 32'(afvalid), 32'd1);
    repeat (4) step();
    afready = 1; step(); afready = 0;
    chk("afvalid_fall", 32'(afvalid), 32'd0);
    bound = 0;
    while (done_pulses == 0 && bound < 20) begin step(); bound++; end
    repeat (4) step();
    chk("flush_done_once", 32'(done_pulses), 32'd1);

    // Sync counter: 64 x 4 bytes, then 90 x 3 bytes.
    do_reset();
    out_ready = 1; atvalid = 1; atbytes = 3'd4; sync_pulses = 0;
    k = 0; bound = 0;
    while (k < 64 && bound < 200) begin
      atdata = $urandom(); step(); bound++;
      if (last_acc) k++;
    end
    atvalid = 0; step(); step();
    atbytes = 3'd3; atvalid = 1; k = 0; bound = 0;
    while (k < 90 && bound < 300) begin
      atdata = $urandom(); step(); bound++;
      if (last_acc) k++;
    end
    atvalid = 0; step(); step();
`ifdef ATB_SINK_SYNCREQ_EN
    chk("sync_pulses", 32'(sync_pulses), 32'd2);
`else
    chk("sync_pulses", 32'(sync_pulses), 32'd0);
`endif

    // Alternating clock enable with continuous valid.
    atvalid = 1; atbytes = 3'd1; out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      atclken = (i % 2 == 0); atdata = $urandom(); atid = 7'($urandom());
      step();
    end
    atclken = 1; atvalid = 0; step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      atclken   = ($urandom_range(0, 3) != 0);
      atvalid   = ($urandom_range(0, 2) != 0);
      atdata    = $urandom();
      atid      = 7'($urandom());
      atbytes   = ($urandom_range(0, 40) == 0) ? 3'($urandom_range(5, 8)) : 3'($urandom_range(1, 4));
      out_ready = ($urandom_range(0, 2) != 0);
      flush_req = ($urandom_range(0, 19) == 0);
      afready   = ($urandom_range(0, 3) == 0);
      step();
    end

    // Asynchronous reset while in FLUSH with a half-full FIFO.
    do_reset();
    atvalid = 1; atbytes = 3'd4; out_ready = 0; k = 0; bound = 0;
    while (k < DEPTH / 2 && bound < 20) begin
      atdata = $urandom(); step(); bound++;
      if (last_acc) k++;
    end
    atvalid = 0; flush_req = 1; step(); flush_req = 0;
    step(); step();
    chk("pre_reset_afvalid", 32'(afvalid), 32'd1);
    #2;
    atresetn = 0;
    #1;
    model_reset();
    idle_inputs();
    check_outputs();
    @(posedge atclk); #1;
    check_outputs();
    atresetn = 1;
    step();
    chk("ready_after_release", 32'(atready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
